// File: rtl/pipe_stage_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_stage_ctrl_if
// Valid/ready payload bundle used on both sides of an elastic pipeline stage.
//
// Signals:
//   valid   : sender presents a payload
//   ready   : receiver can take the payload this cycle
//   data    : payload, DATA_W bits
//   noflush : tag travelling with the payload (survives flush when the
//             stage is built with PIPE_STAGE_NOFLUSH_EN)
//
// Modports:
//   master : the side that produces payloads (drives valid/data/noflush)
//   slave  : the side that consumes payloads (drives ready)
// ---------------------------------------------------------------------------
interface pipe_stage_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              noflush;

  modport master (
    output valid,
    output data,
    output noflush,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  noflush,
    output ready
  );
endinterface

// File: rtl/pipe_stage_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_stage_ctrl
// Elastic pipeline-stage register with a 2-entry skid buffer (main entry M
// feeding the outputs, skid entry S catching one payload under backpressure).
// Upstream ready is a register that depends only on whether S is occupied,
// so there is no combinational path from out_ready to in_ready.
//
// Parameters:
//   DATA_W      : payload width (1..256)
//   CLEAR_VAL   : value held in any empty entry, seen on dn.data when idle
//   STALL_CNT_W : width of the saturating stall-cycle counter
//
// Ports:
//   clk       : rising-edge clock
//   reset_n   : asynchronous active-low reset
//   up        : upstream bundle (slave):   in_valid/in_ready/in_data/in_noflush
//   dn        : downstream bundle (master): out_valid/out_ready/out_data/out_noflush
//   flush     : synchronous kill of held entries, priority over accept/pop
//   stall_cnt : cycles with dn.valid=1 and dn.ready=0, saturating, not flushed
//
// Configuration macro:
//   PIPE_STAGE_NOFLUSH_EN : when defined, flush only kills entries whose
//   noflush tag is 0; tagged entries (and a tagged payload offered during
//   flush) survive and are compacted towards M in FIFO order.
// ---------------------------------------------------------------------------
module pipe_stage_ctrl #(
  parameter int                DATA_W      = 32,
  parameter logic [DATA_W-1:0] CLEAR_VAL   = {DATA_W{1'b0}},
  parameter int                STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  pipe_stage_ctrl_if.slave       up,
  pipe_stage_ctrl_if.master      dn,
  input  logic                   flush,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  // Main entry (drives the outputs)
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_noflush;

  // Skid entry (only occupied while downstream is stalled)
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_noflush;

  logic              in_ready;

  // Next-state values
  logic              m_valid_nxt;
  logic [DATA_W-1:0] m_data_nxt;
  logic              m_noflush_nxt;
  logic              s_valid_nxt;
  logic [DATA_W-1:0] s_data_nxt;
  logic              s_noflush_nxt;

  logic acc;
  logic pop;
  logic keep_m;
  logic keep_s;
  logic keep_in;
  logic stall_inc;

  assign acc = up.valid & in_ready;
  assign pop = m_valid & dn.ready;

  // Survivor terms. Every update (normal or flush) is expressed as: the
  // surviving entries, oldest first, are packed into M then S. Without a
  // flush, M survives unless popped, S always survives, and an accepted
  // payload survives. A pop always removes M, even in a flush cycle.
`ifdef PIPE_STAGE_NOFLUSH_EN
  assign keep_m  = m_valid & ~pop & (~flush | m_noflush);
  assign keep_s  = s_valid & (~flush | s_noflush);
  assign keep_in = acc & (~flush | up.noflush);
`else
  assign keep_m  = m_valid & ~pop & ~flush;
  assign keep_s  = s_valid & ~flush;
  assign keep_in = acc & ~flush;
`endif

  // Stall counting stops at all-ones; flush does not touch it.
  assign stall_inc = m_valid & ~dn.ready & ~(&stall_cnt);

  // Next-state packing of surviving entries into M/S; empty entries get CLEAR_VAL
  always_comb begin
    m_valid_nxt   = 1'b0;
    m_data_nxt    = CLEAR_VAL;
    m_noflush_nxt = 1'b0;
    s_valid_nxt   = 1'b0;
    s_data_nxt    = CLEAR_VAL;
    s_noflush_nxt = 1'b0;
    if (keep_m) begin
      m_valid_nxt   = 1'b1;
      m_data_nxt    = m_data;
      m_noflush_nxt = m_noflush;
      if (keep_s) begin
        s_valid_nxt   = 1'b1;
        s_data_nxt    = s_data;
        s_noflush_nxt = s_noflush;
      end else if (keep_in) begin
        // Downstream stalled: the new payload lands in the skid entry
        s_valid_nxt   = 1'b1;
        s_data_nxt    = up.data;
        s_noflush_nxt = up.noflush;
      end else begin
        s_valid_nxt   = 1'b0;
        s_data_nxt    = CLEAR_VAL;
        s_noflush_nxt = 1'b0;
      end
    end else if (keep_s) begin
      // M leaves (popped or killed): skid entry moves forward. keep_in is
      // impossible here because in_ready was low while S was occupied.
      m_valid_nxt   = 1'b1;
      m_data_nxt    = s_data;
      m_noflush_nxt = s_noflush;
      if (keep_in) begin
        s_valid_nxt   = 1'b1;
        s_data_nxt    = up.data;
        s_noflush_nxt = up.noflush;
      end else begin
        s_valid_nxt   = 1'b0;
        s_data_nxt    = CLEAR_VAL;
        s_noflush_nxt = 1'b0;
      end
    end else if (keep_in) begin
      m_valid_nxt   = 1'b1;
      m_data_nxt    = up.data;
      m_noflush_nxt = up.noflush;
    end else begin
      m_valid_nxt   = 1'b0;
      m_data_nxt    = CLEAR_VAL;
      m_noflush_nxt = 1'b0;
    end
  end

  // Entry registers and registered upstream ready
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_valid   <= 1'b0;
      m_data    <= CLEAR_VAL;
      m_noflush <= 1'b0;
      s_valid   <= 1'b0;
      s_data    <= CLEAR_VAL;
      s_noflush <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      m_valid   <= m_valid_nxt;
      m_data    <= m_data_nxt;
      m_noflush <= m_noflush_nxt;
      s_valid   <= s_valid_nxt;
      s_data    <= s_data_nxt;
      s_noflush <= s_noflush_nxt;
      // Mirrors ~s_valid exactly, kept as its own flop for a clean output
      in_ready  <= ~s_valid_nxt;
    end
  end

  // Saturating stall-cycle counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= {STALL_CNT_W{1'b0}};
    end else if (stall_inc) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end else begin
      stall_cnt <= stall_cnt;
    end
  end

  assign up.ready   = in_ready;
  assign dn.valid   = m_valid;
  assign dn.data    = m_data;
  assign dn.noflush = m_noflush;

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_ctrl
// Directed + short random bench for pipe_stage_ctrl. A queue holds the
// payloads the bench expects the stage to hold (front = main entry); entries
// are pushed when the bench drives an accepted payload and the front is
// compared with the DUT outputs every cycle and removed on pop.
// ---------------------------------------------------------------------------
module tb_pipe_stage_ctrl;

  localparam int                DW    = 32;
  localparam logic [DW-1:0]     CLR   = 32'hDEAD_BEEF;
  localparam int                SCW   = 4;
  localparam int                SMAX  = 15;

  typedef struct {
    logic [DW-1:0] data;
    logic          nf;
  } ent_t;

  logic             clk;
  logic             reset_n;
  logic             flush;
  logic [SCW-1:0]   stall_cnt;

  pipe_stage_ctrl_if #(.DATA_W(DW)) up_if ();
  pipe_stage_ctrl_if #(.DATA_W(DW)) dn_if ();

  pipe_stage_ctrl #(
    .DATA_W      (DW),
    .CLEAR_VAL   (CLR),
    .STALL_CNT_W (SCW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .up        (up_if.slave),
    .dn        (dn_if.master),
    .flush     (flush),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ent_t q[$];
  int   stall_m;
  int   total;
  int   passed;
  int   fails;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    total++;
    assert (obs === want) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Compare every DUT output against the model state
  task automatic check_all(input string tag);
    logic [DW-1:0] d;
    logic          nf;
    d  = (q.size() > 0) ? q[0].data : CLR;
    nf = (q.size() > 0) ? q[0].nf : 1'b0;
    chk({tag, ".out_valid"},   64'(dn_if.valid),   64'(q.size() > 0));
    chk({tag, ".in_ready"},    64'(up_if.ready),   64'(q.size() < 2));
    chk({tag, ".out_data"},    64'(dn_if.data),    64'(d));
    chk({tag, ".out_noflush"}, 64'(dn_if.noflush), 64'(nf));
    chk({tag, ".stall_cnt"},   64'(stall_cnt),     64'(stall_m));
  endtask

  // One clock: drive inputs, step the model at the edge, check 1 time unit later
  task automatic step(input string tag, input logic vld, input logic [DW-1:0] d,
                      input logic nf, input logic rdy, input logic fl);
    bit   acc;
    bit   pop;
    ent_t e;
    ent_t keep[$];
    up_if.valid   = vld;
    up_if.data    = d;
    up_if.noflush = nf;
    dn_if.ready   = rdy;
    flush         = fl;
    acc = vld && (q.size() < 2);
    pop = (q.size() > 0) && rdy;
    e.data = d;
    e.nf   = nf;
    @(posedge clk);
    if (q.size() > 0 && !rdy && stall_m < SMAX) stall_m++;
    if (pop) void'(q.pop_front());
    if (fl) begin
`ifdef PIPE_STAGE_NOFLUSH_EN
      keep = {};
      foreach (q[i]) if (q[i].nf) keep.push_back(q[i]);
      q = keep;
      if (acc && nf) q.push_back(e);
`else
      q.delete();
`endif
    end else if (acc) begin
      q.push_back(e);
    end
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    up_if.valid   = 1'b0;
    up_if.data    = '0;
    up_if.noflush = 1'b0;
    dn_if.ready   = 1'b0;
    flush         = 1'b0;
    reset_n       = 1'b0;
    q.delete();
    stall_m = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset_n = 1'b1;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    fails  = 0;

    do_reset();

    // Streaming at full throughput
    step("stream0", 1'b1, 32'h1, 1'b0, 1'b1, 1'b0);
    step("stream1", 1'b1, 32'h2, 1'b0, 1'b1, 1'b0);
    step("stream2", 1'b1, 32'h3, 1'b0, 1'b1, 1'b0);
    step("stream3", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    // Backpressure into the skid entry, then drain
    step("skid0", 1'b1, 32'hA, 1'b0, 1'b1, 1'b0);
    step("skid1", 1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
    step("skid2", 1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
    step("skid3", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step("skid4", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step("skid5", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    // Flush with both entries full and a payload offered
    do_reset();
    step("fl_ld0", 1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
    step("fl_ld1", 1'b1, 32'hB, 1'b1, 1'b0, 1'b0);
    step("fl_kill", 1'b1, 32'hC, 1'b1, 1'b0, 1'b1);
    step("fl_after", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    // Tagged survivor moving from S to M on flush
    do_reset();
    step("nf_ld0", 1'b1, 32'h5, 1'b0, 1'b0, 1'b0);
    step("nf_ld1", 1'b1, 32'h6, 1'b1, 1'b0, 1'b0);
    step("nf_flush", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    step("nf_drain", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    // Payloads offered during flush (tagged / untagged) and pop during flush
    step("nf_in1", 1'b1, 32'h7, 1'b1, 1'b0, 1'b1);
    step("nf_in0", 1'b1, 32'h8, 1'b0, 1'b1, 1'b1);
    step("nf_pop", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    step("nf_end", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    // Stall counter saturation
    do_reset();
    step("sat_ld", 1'b1, 32'h9, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step("sat", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step("sat_flush", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    step("sat_hold", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    // Async reset mid-operation with both entries full
    do_reset();
    step("ar_ld0", 1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
    step("ar_ld1", 1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    q.delete();
    stall_m = 0;
    #1;
    check_all("async_rst");
    #2;
    reset_n = 1'b1;
    step("ar_first", 1'b1, 32'h11, 1'b0, 1'b1, 1'b0);
    step("ar_next", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    // Random traffic for ordering / no loss or duplication
    for (int i = 0; i < 300; i++) begin
      step("rand", 1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_stage_ctrl.md
Name: pipe_stage_ctrl

Overview:
Parametrised, elastic pipeline-stage register for control/data bundles between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It generalises the fixed-field stage register to a DATA_W-wide payload. It adds a valid/ready handshake with a 2-entry skid buffer, so backpressure never needs a combinational ready path. Flush clears all held entries to a programmable clear value, which makes them bubbles.

Parameters:
DATA_W, 32, payload width in bits (1..256)
CLEAR_VAL, {DATA_W{1'b0}}, value driven on out_data when the stage is empty or after flush/reset
STALL_CNT_W, 16, width of the stall-cycle counter

Ports:
clk  in  1  single clock, rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream presents a payload
in_ready  out  1  stage can accept; registered, depends only on the skid-entry state
in_data  in  DATA_W  upstream payload
in_noflush  in  1  tag carried with the payload (see Optional Feature)
flush  in  1  synchronous kill of all held entries
out_valid  out  1  main entry holds a payload
out_ready  in  1  downstream accepts
out_data  out  DATA_W  main-entry payload; CLEAR_VAL when out_valid=0
out_noflush  out  1  tag of the main entry; 0 when out_valid=0
stall_cnt  out  STALL_CNT_W  count of cycles with out_valid=1 and out_ready=0; saturating

Behaviour:
- Storage: main entry M (valid, data, noflush) and skid entry S (valid, data, noflush). Outputs are driven only from M.
- Handshake definitions:
  - acc = in_valid & in_ready
  - pop = out_valid & out_ready
  - in_ready = ~S.valid
- Latency: 1 cycle from accept to out_valid. Sustained throughput is 1 payload/cycle when out_ready=1.
- Next state, no flush:
  - M empty, acc: M <= in.
  - M full, pop, S empty, acc: M <= in.
  - M full, pop, S empty, no acc: M empties.
  - M full, pop, S full: M <= S, S empties. in_ready was 0, so no accept is possible.
  - M full, no pop, acc: S <= in (skid). in_ready drops to 0 next cycle.
  - M full, no pop, no acc: hold.
- Ordering is strictly FIFO; no payload is duplicated or lost.
- Flush (synchronous) has priority over acc and pop:
  - M.valid and S.valid clear next cycle.
  - A payload offered in the flush cycle is discarded, even if in_ready=1.
  - A pop in the flush cycle still counts as consumed downstream; the stage does not re-present it.
- Empty data: whenever an entry is invalid, its data register is loaded with CLEAR_VAL and its noflush bit with 0. As a result, out_data=CLEAR_VAL whenever out_valid=0.
- stall_cnt: +1 each cycle with out_valid & ~out_ready. It saturates at all-ones and is not cleared by flush.
- Reset (reset_n=0, asynchronous, any cycle including mid-transfer):
  - out_valid=0, in_ready=1, out_data=CLEAR_VAL, out_noflush=0, stall_cnt=0.
  - S is cleared.
  - Deassertion is used synchronously; the first accept can occur on the first clk edge after release.
- in_data is don't-care when in_valid=0. out_ready is don't-care when out_valid=0.

Optional Feature:
Macro: PIPE_STAGE_NOFLUSH_EN
- Defined:
  - flush kills only entries whose noflush=0; entries with noflush=1 survive.
  - If M is killed and S survives, S moves to M in the same edge and S empties.
  - A payload offered during flush with in_noflush=1 is accepted normally under the usual acc rule.
  - A pop during flush removes M regardless of its tag.
- Not defined:
  - in_noflush is ignored by the flush logic but is still carried through to out_noflush.
  - flush kills everything.

Test Plan:
- Streaming: DATA_W=32, out_ready=1, in_valid=1 with data 0x1,0x2,0x3 on cycles 0..2 -> out_data 0x1,0x2,0x3 on cycles 1..3 with out_valid=1; in_ready stays 1; stall_cnt=0.
- Backpressure/skid: out_ready=0 from cycle 1; offer 0xA (cycle 0) and 0xB (cycle 1) -> cycle 2 in_ready=0, out_data=0xA. With out_ready=1 at cycle 4 -> cycle 5 out_data=0xB, in_ready=1; stall_cnt=3.
- Flush priority: M=0xA, S=0xB, in_valid=1 with 0xC, flush=1 -> next cycle out_valid=0, out_data=CLEAR_VAL, in_ready=1; 0xC never appears.
- Async reset mid-operation: reset_n low between clock edges while M and S are full -> outputs go immediately to out_valid=0, out_data=CLEAR_VAL, in_ready=1, stall_cnt=0.
- Saturation: STALL_CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt=15 and holds.
- PIPE_STAGE_NOFLUSH_EN defined: M=0x5 (noflush=0), S=0x6 (noflush=1), flush=1, out_ready=0 -> next cycle out_valid=1, out_data=0x6, out_noflush=1, in_ready=1. With the macro undefined, the same stimulus gives out_valid=0.
